// File: rtl/bin_pkg.sv
// Shared definitions for the parametrised binner: FSM state encoding,
// default widths and the width of the signed offset/edge comparison.
package bin_pkg;

    typedef enum logic {
        BIN_IDLE   = 1'b0,
        BIN_SEARCH = 1'b1
    } bin_state_t;

    localparam int DEF_VAL_W   = 32;
    localparam int DEF_BIN_W   = 6;
    localparam int DEF_WIDTH_W = 16;
    localparam int DEF_ORG_W   = 16;
    localparam int DEF_HIST_W  = 16;

    // Offset is VAL_W+1 signed; one more bit keeps the zero-extended
    // product comparison free of sign ambiguity.
    function automatic int cmp_width(input int val_w);
        return val_w + 2;
    endfunction

endpackage

// File: rtl/bin_hist_counters.sv
// Per-bin saturating hit counters with a registered read port.
// Only instantiated when BIN_HIST_EN is defined.
module bin_hist_counters
    import bin_pkg::*;
#(
    parameter int BIN_W  = DEF_BIN_W,
    parameter int HIST_W = DEF_HIST_W
) (
    input  logic              clk100,
    input  logic              rst_n,
    input  logic              hist_clr,
    input  logic              incr,
    input  logic [BIN_W-1:0]  incr_idx,
    input  logic [BIN_W-1:0]  rd_idx,
    output logic [HIST_W-1:0] rd_data
);

    localparam int NUM_BINS = 2 ** BIN_W;

    logic [HIST_W-1:0] cnt_q [NUM_BINS];
    logic [HIST_W-1:0] rd_data_reg;

    generate
        for (genvar gi = 0; gi < NUM_BINS; gi++) begin : g_cnt
            logic [HIST_W-1:0] cnt_reg;

            // Clear has priority over a coincident increment; counts saturate.
            always_ff @(posedge clk100 or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (hist_clr) begin
                    cnt_reg <= '0;
                end else if (incr && (incr_idx == BIN_W'(gi)) && (cnt_reg != '1)) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            assign cnt_q[gi] = cnt_reg;
        end
    endgenerate

    // Read mux registered: data valid one cycle after rd_idx.
    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_reg <= '0;
        end else begin
            rd_data_reg <= cnt_q[rd_idx];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/bin_search_param.sv
// Maps a signed sample onto one of num_bins equal-width bins starting at
// origin using a fixed-latency successive-approximation search (one bit per
// cycle, MSB first). Operands are captured on acceptance so the ports may
// change during a search. Optional per-bin histogram under BIN_HIST_EN.
module bin_search_param
    import bin_pkg::*;
#(
    parameter int VAL_W   = DEF_VAL_W,
    parameter int BIN_W   = DEF_BIN_W,
    parameter int WIDTH_W = DEF_WIDTH_W,
    parameter int ORG_W   = DEF_ORG_W,
    parameter int HIST_W  = DEF_HIST_W
) (
    input  logic               clk100,
    input  logic               rst_n,
    input  logic               data_in,
    input  logic [VAL_W-1:0]   value,
    input  logic [BIN_W:0]     num_bins,
    input  logic [WIDTH_W-1:0] bin_width,
    input  logic [ORG_W-1:0]   origin,
`ifdef BIN_HIST_EN
    input  logic               hist_clr,
    input  logic [BIN_W-1:0]   hist_rd_idx,
    output logic [HIST_W-1:0]  hist_rd_data,
`endif
    output logic               busy,
    output logic               binned,
    output logic [BIN_W-1:0]   current,
    output logic               underflow,
    output logic               overflow,
    output logic               dropped
);

    localparam int OFF_W  = VAL_W + 1;
    localparam int CMP_W  = cmp_width(VAL_W);
    localparam int PROD_W = BIN_W + WIDTH_W;
    localparam int TOT_W  = PROD_W + 1;
    localparam int PTR_W  = $clog2(BIN_W + 1);

    bin_state_t state_reg, state_next;

    logic signed [OFF_W-1:0] offset_reg;
    logic [BIN_W:0]          num_bins_reg;
    logic [WIDTH_W-1:0]      bin_width_reg;
    logic [PTR_W-1:0]        bit_ptr_reg;
    logic [BIN_W-1:0]        result_reg;

    logic                    binned_reg;
    logic [BIN_W-1:0]        current_reg;
    logic                    underflow_reg;
    logic                    overflow_reg;
    logic                    dropped_reg;

    logic                    accept;
    logic                    finish;

    logic signed [OFF_W-1:0] offset_next;
    logic signed [CMP_W-1:0] offset_cmp;
    logic [BIN_W-1:0]        cand;
    logic [PROD_W-1:0]       product;
    logic signed [CMP_W-1:0] product_cmp;
    logic                    keep;
    logic [BIN_W-1:0]        result_step;
    logic [TOT_W-1:0]        total;
    logic signed [CMP_W-1:0] total_cmp;

    // Offset of the incoming sample from the lower edge of bin 0.
    assign offset_next = $signed({value[VAL_W-1], value})
                       - $signed({{(OFF_W-ORG_W){origin[ORG_W-1]}}, origin});

    // One search step: try setting the current bit, keep it if the candidate
    // bin exists and its lower edge does not exceed the offset.
    assign offset_cmp  = {{(CMP_W-OFF_W){offset_reg[OFF_W-1]}}, offset_reg};
    assign cand        = result_reg | (BIN_W'(1) << bit_ptr_reg);
    assign product     = {{WIDTH_W{1'b0}}, cand} * {{BIN_W{1'b0}}, bin_width_reg};
    assign product_cmp = {{(CMP_W-PROD_W){1'b0}}, product};
    assign keep        = ({1'b0, cand} < num_bins_reg) && (offset_cmp >= product_cmp);
    assign result_step = keep ? cand : result_reg;

    // Upper edge of the last bin for the overflow flag.
    assign total     = {{WIDTH_W{1'b0}}, num_bins_reg} * {{(BIN_W+1){1'b0}}, bin_width_reg};
    assign total_cmp = {{(CMP_W-TOT_W){1'b0}}, total};

    // State register.
    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= BIN_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: accept in IDLE, finish when the last bit is tried.
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state_reg)
            BIN_IDLE: begin
                if (data_in) begin
                    accept     = 1'b1;
                    state_next = BIN_SEARCH;
                end
            end
            BIN_SEARCH: begin
                if (bit_ptr_reg == '0) begin
                    finish     = 1'b1;
                    state_next = BIN_IDLE;
                end
            end
            default: state_next = BIN_IDLE;
        endcase
    end

    // Operand capture, search iteration and registered result outputs.
    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            offset_reg    <= '0;
            num_bins_reg  <= '0;
            bin_width_reg <= '0;
            bit_ptr_reg   <= '0;
            result_reg    <= '0;
            binned_reg    <= 1'b0;
            current_reg   <= '0;
            underflow_reg <= 1'b0;
            overflow_reg  <= 1'b0;
            dropped_reg   <= 1'b0;
        end else begin
            binned_reg  <= finish;
            dropped_reg <= data_in && (state_reg == BIN_SEARCH);
            if (accept) begin
                offset_reg    <= offset_next;
                num_bins_reg  <= num_bins;
                bin_width_reg <= bin_width;
                bit_ptr_reg   <= PTR_W'(BIN_W - 1);
                result_reg    <= '0;
            end else if (state_reg == BIN_SEARCH) begin
                result_reg  <= result_step;
                bit_ptr_reg <= bit_ptr_reg - 1'b1;
            end
            if (finish) begin
                current_reg   <= result_step;
                underflow_reg <= offset_reg[OFF_W-1];
                overflow_reg  <= (num_bins_reg == '0) || (offset_cmp >= total_cmp);
            end
        end
    end

    assign busy      = (state_reg == BIN_SEARCH);
    assign binned    = binned_reg;
    assign current   = current_reg;
    assign underflow = underflow_reg;
    assign overflow  = overflow_reg;
    assign dropped   = dropped_reg;

`ifdef BIN_HIST_EN
    bin_hist_counters #(
        .BIN_W  (BIN_W),
        .HIST_W (HIST_W)
    ) u_hist (
        .clk100   (clk100),
        .rst_n    (rst_n),
        .hist_clr (hist_clr),
        .incr     (binned_reg),
        .incr_idx (current_reg),
        .rd_idx   (hist_rd_idx),
        .rd_data  (hist_rd_data)
    );
`else
    logic unused_hist_cfg;
    assign unused_hist_cfg = (HIST_W > 0);
`endif

endmodule

// File: tb/tb_bin_search_param.sv
// Directed, table-driven bench for bin_search_param, plus hand-written
// sequences for drop, mid-search reset and (with BIN_HIST_EN) histogram.
module tb_bin_search_param;

    localparam int VAL_W   = 32;
    localparam int BIN_W   = 6;
    localparam int WIDTH_W = 16;
    localparam int ORG_W   = 16;
    localparam int HIST_W  = 16;

    logic               clk100;
    logic               rst_n;
    logic               data_in;
    logic [VAL_W-1:0]   value;
    logic [BIN_W:0]     num_bins;
    logic [WIDTH_W-1:0] bin_width;
    logic [ORG_W-1:0]   origin;
    logic               busy;
    logic               binned;
    logic [BIN_W-1:0]   current;
    logic               underflow;
    logic               overflow;
    logic               dropped;
`ifdef BIN_HIST_EN
    logic               hist_clr;
    logic [BIN_W-1:0]   hist_rd_idx;
    logic [HIST_W-1:0]  hist_rd_data;
`endif

    int checks = 0;
    int errors = 0;

    bin_search_param #(
        .VAL_W   (VAL_W),
        .BIN_W   (BIN_W),
        .WIDTH_W (WIDTH_W),
        .ORG_W   (ORG_W),
        .HIST_W  (HIST_W)
    ) dut (
        .clk100    (clk100),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .value     (value),
        .num_bins  (num_bins),
        .bin_width (bin_width),
        .origin    (origin),
`ifdef BIN_HIST_EN
        .hist_clr     (hist_clr),
        .hist_rd_idx  (hist_rd_idx),
        .hist_rd_data (hist_rd_data),
`endif
        .busy      (busy),
        .binned    (binned),
        .current   (current),
        .underflow (underflow),
        .overflow  (overflow),
        .dropped   (dropped)
    );

    initial clk100 = 1'b0;
    always #5 clk100 = ~clk100;

    typedef struct {
        logic signed [31:0] val;
        logic [6:0]         nb;
        logic [15:0]        bw;
        logic signed [15:0] org;
        logic [5:0]         cur;
        logic               uf;
        logic               of;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Apply one sample, scramble the ports during the search, then check
    // latency, busy length and the registered result.
    task automatic run_vec(input vec_t v, input int tag);
        int lat;
        int bcnt;
        @(negedge clk100);
        value     = v.val;
        num_bins  = v.nb;
        bin_width = v.bw;
        origin    = v.org;
        data_in   = 1'b1;
        @(negedge clk100);
        data_in   = 1'b0;
        value     = ~value;
        num_bins  = 7'd0;
        bin_width = 16'hffff;
        origin    = ~origin;
        lat  = 0;
        bcnt = 0;
        while (!binned && lat < BIN_W + 10) begin
            if (busy) bcnt++;
            @(negedge clk100);
            lat++;
        end
        chk($sformatf("latency[%0d]", tag), 64'(lat), 64'(BIN_W));
        chk($sformatf("busy_len[%0d]", tag), 64'(bcnt), 64'(BIN_W));
        chk($sformatf("current[%0d]", tag), 64'(current), 64'(v.cur));
        chk($sformatf("underflow[%0d]", tag), 64'(underflow), 64'(v.uf));
        chk($sformatf("overflow[%0d]", tag), 64'(overflow), 64'(v.of));
        $display("vec %0d value=%0d nb=%0d bw=%0d org=%0d -> current=%0d uf=%0b of=%0b lat=%0d",
                 tag, v.val, v.nb, v.bw, v.org, current, underflow, overflow, lat);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nbin;
        vec_t hv;

        vecs[0]  = '{32'sd5,           7'd20, 16'd1,     16'sd0,     6'd5,  1'b0, 1'b0};
        vecs[1]  = '{-32'sd1,          7'd20, 16'd1,     16'sd0,     6'd0,  1'b1, 1'b0};
        vecs[2]  = '{32'sd25,          7'd20, 16'd1,     16'sd0,     6'd19, 1'b0, 1'b1};
        vecs[3]  = '{32'sd3,           7'd20, 16'd4,     -16'sd10,   6'd3,  1'b0, 1'b0};
        vecs[4]  = '{32'sd70,          7'd20, 16'd4,     -16'sd10,   6'd19, 1'b0, 1'b1};
        vecs[5]  = '{32'sd69,          7'd20, 16'd4,     -16'sd10,   6'd19, 1'b0, 1'b0};
        vecs[6]  = '{-32'sd2,          7'd20, 16'd4,     -16'sd10,   6'd2,  1'b0, 1'b0};
        vecs[7]  = '{32'sd5,           7'd0,  16'd1,     16'sd0,     6'd0,  1'b0, 1'b1};
        vecs[8]  = '{32'sd5,           7'd20, 16'd0,     16'sd0,     6'd19, 1'b0, 1'b1};
        vecs[9]  = '{32'sd63,          7'd64, 16'd1,     16'sd0,     6'd63, 1'b0, 1'b0};
        vecs[10] = '{32'sd64,          7'd64, 16'd1,     16'sd0,     6'd63, 1'b0, 1'b1};
        vecs[11] = '{32'sd50099,       7'd50, 16'd1000,  16'sd100,   6'd49, 1'b0, 1'b0};
        vecs[12] = '{32'sd50100,       7'd50, 16'd1000,  16'sd100,   6'd49, 1'b0, 1'b1};
        vecs[13] = '{-32'sd5,          7'd0,  16'd1,     16'sd0,     6'd0,  1'b1, 1'b1};
        vecs[14] = '{32'sh80000000,    7'd20, 16'd1,     16'sh7fff,  6'd0,  1'b1, 1'b0};
        vecs[15] = '{32'sh7fffffff,    7'd64, 16'hffff,  16'sh8000,  6'd63, 1'b0, 1'b1};

        rst_n     = 1'b0;
        data_in   = 1'b0;
        value     = '0;
        num_bins  = 7'd20;
        bin_width = 16'd1;
        origin    = '0;
`ifdef BIN_HIST_EN
        hist_clr    = 1'b0;
        hist_rd_idx = '0;
`endif

        // Reset state
        repeat (3) @(negedge clk100);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_binned", 64'(binned), 64'd0);
        chk("rst_current", 64'(current), 64'd0);
        chk("rst_underflow", 64'(underflow), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_dropped", 64'(dropped), 64'd0);
        rst_n = 1'b1;
        @(negedge clk100);

        for (int i = 0; i < NVEC; i++) begin
            run_vec(vecs[i], i);
        end

        // Result held after the strobe
        @(negedge clk100);
        chk("hold_binned", 64'(binned), 64'd0);
        chk("hold_current", 64'(current), 64'd63);
        chk("hold_overflow", 64'(overflow), 64'd1);

        // Drop while busy at edge 3 and at the final search edge
        @(negedge clk100);
        value = 32'd5; num_bins = 7'd20; bin_width = 16'd1; origin = '0;
        data_in = 1'b1;
        @(negedge clk100);
        data_in = 1'b0;
        chk("drop_n1_dropped", 64'(dropped), 64'd0);
        @(negedge clk100);
        @(negedge clk100);
        value = 32'd9;
        data_in = 1'b1;
        @(negedge clk100);
        chk("drop_n4_dropped", 64'(dropped), 64'd1);
        chk("drop_n4_busy", 64'(busy), 64'd1);
        data_in = 1'b0;
        @(negedge clk100);
        chk("drop_n5_dropped", 64'(dropped), 64'd0);
        @(negedge clk100);
        data_in = 1'b1;
        @(negedge clk100);
        chk("drop_n7_binned", 64'(binned), 64'd1);
        chk("drop_n7_current", 64'(current), 64'd5);
        chk("drop_n7_dropped", 64'(dropped), 64'd1);
        chk("drop_n7_busy", 64'(busy), 64'd0);
        data_in = 1'b0;
        @(negedge clk100);
        chk("drop_n8_busy", 64'(busy), 64'd0);
        chk("drop_n8_binned", 64'(binned), 64'd0);
        chk("drop_n8_dropped", 64'(dropped), 64'd0);
        nbin = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk100);
            if (binned) nbin++;
        end
        chk("drop_extra_binned", 64'(nbin), 64'd0);
        $display("drop sequence current=%0d extra_binned=%0d", current, nbin);

        // Reset mid-search
        @(negedge clk100);
        value = 32'd7;
        data_in = 1'b1;
        @(negedge clk100);
        data_in = 1'b0;
        @(negedge clk100);
        @(negedge clk100);
        @(negedge clk100);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_current", 64'(current), 64'd0);
        chk("midrst_binned", 64'(binned), 64'd0);
        @(negedge clk100);
        rst_n = 1'b1;
        nbin = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk100);
            if (binned) nbin++;
        end
        chk("midrst_no_binned", 64'(nbin), 64'd0);
        chk("midrst_current_after", 64'(current), 64'd0);
        $display("mid-search reset current=%0d binned_after=%0d", current, nbin);

`ifdef BIN_HIST_EN
        // Histogram: even samples 0..38 into 20 unit bins; 20..38 clamp to bin 19
        for (int v = 0; v < 40; v += 2) begin
            hv = '{32'(v), 7'd20, 16'd1, 16'sd0,
                   (v < 20) ? 6'(v) : 6'd19, 1'b0, (v >= 20) ? 1'b1 : 1'b0};
            run_vec(hv, 100 + v);
        end
        @(negedge clk100);
        for (int b = 0; b < 20; b++) begin
            hist_rd_idx = 6'(b);
            @(negedge clk100);
            chk($sformatf("hist[%0d]", b), 64'(hist_rd_data),
                (b == 19) ? 64'd10 : ((b % 2 == 0) ? 64'd1 : 64'd0));
            $display("hist read idx=%0d data=%0d", b, hist_rd_data);
        end
        hist_clr = 1'b1;
        @(negedge clk100);
        hist_clr = 1'b0;
        for (int b = 0; b < 20; b++) begin
            hist_rd_idx = 6'(b);
            @(negedge clk100);
            chk($sformatf("hist_clr[%0d]", b), 64'(hist_rd_data), 64'd0);
        end
        $display("hist cleared");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
